mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-port request arbiter that sits directly upstream of the external memory controller. It merges the core's instruction-fetch port and its load/store port onto the controller's single WE/A/WD/RD/mem_ready interface. It applies round-robin arbitration, issues one start pulse per access and detects completion, and converts a hung access into an error response after a timeout. An optional one-entry posted write buffer can be compiled in.

## Interface
Parameters:
- TIMEOUT_CYCLES, 2048: WAIT-state cycles before an access is abandoned. Must be ≥ 2.
- ERR_DATA, 32'hDEADBEEF: read data returned on timeout.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction read request; held high until i_ack
- i_addr  in  32  instruction address; stable while i_req is high
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  32  read data; valid with i_ack, held until next i_ack
- i_err  out  1  qualifies i_ack; access timed out
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  load data; valid with d_ack
- d_err  out  1  qualifies d_ack
- mem_req  out  1  one-cycle start pulse to the controller
- mem_we  out  1  write enable, held from mem_req until completion
- mem_addr  out  32  address, held likewise
- mem_wdata  out  32  write data, held likewise
- mem_rdata  in  32  controller read data, sampled at completion
- mem_ready  in  1  controller ready/done
- wb_err  out  1  sticky: a buffered write timed out; tied 0 without the buffer

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when any requester is pending.
  - ISSUE → HOLD.
  - HOLD → WAIT.
  - WAIT → IDLE on mem_ready = 1 or on timeout.
- IDLE selects a winner and latches the winner's we/addr/wdata into the mem_* registers. The grant holder is a 2-bit one-hot register.
- ISSUE: mem_req = 1 for exactly this cycle.
- HOLD: mem_ready is ignored for this one cycle, covering the controller's busy indication.
- WAIT:
  - Completion: mem_ready = 1 → capture mem_rdata to the winner's rdata, pulse the winner's ack for one cycle, err = 0.
  - Timeout: counter reaches TIMEOUT_CYCLES-1 with mem_ready still 0 → ack with err = 1 and rdata = ERR_DATA.
  - The counter clears on entry to WAIT.
- Arbitration:
  - Priority order is write-buffer drain (if present), then I/D.
  - When both i_req and d_req are pending, the port not granted last wins. The last_grant bit updates at each grant.
  - A lone requester wins immediately.
- Back-to-back: a req still high in the cycle after its ack is a new request.
- Stores (no buffer): complete only when the downstream access completes. d_rdata holds its previous value on store acks.
- Reset (any time, including mid-access):
  - state = IDLE, all ack/err/mem_req = 0, mem_we = 0.
  - mem_addr/mem_wdata/i_rdata/d_rdata = 0.
  - last_grant = D, so the first tie goes to I.
  - Timeout counter = 0, wb_err = 0, write buffer empty.
  - An interrupted access is lost with no ack.

## Timing
- Cycle 0: request sampled in IDLE.
- Cycle 1: mem_req.
- Cycle 2: HOLD.
- Earliest ack is cycle 3, when mem_ready = 1 in cycle 3.
- Timeout ack at cycle 2 + TIMEOUT_CYCLES.
- Minimum spacing between mem_req pulses is 4 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
Macro: MEM_ARB_WRITE_BUFFER_EN.

With the macro defined:
- Write buffer: one entry holding address, data and valid.
- Store acceptance:
  - A store is accepted into an empty buffer in any FSM state.
  - d_ack pulses the following cycle with d_err = 0. The D port is not arbitrated for that store.
- Drain:
  - The buffer drains as a mem_we = 1 access with top priority in IDLE.
  - It empties at completion.
  - A drain timeout sets wb_err.
- Loads:
  - A load whose address equals the valid buffer address is forwarded: d_ack next cycle with d_rdata = buffered data, no downstream access.
  - Other loads arbitrate normally, but not before a pending drain.
- A store arriving while the buffer is full waits until the drain completes, then is buffered.

Without the macro: no buffer, stores arbitrate as above, and wb_err = 0.

## Test plan
- Lone fetch, i_addr = 0x100, mem_ready dropped cycle 2 and raised cycle 5, mem_rdata = 0x12345678 → mem_req in cycle 1 only; i_ack in cycle 5 with i_rdata = 0x12345678, i_err = 0.
- i_req and d_req (load 0x200) both high from reset, held continuously → grant order I, D, I, D; mem_req pulses at least 4 cycles apart.
- mem_ready held 0 after issue, TIMEOUT_CYCLES = 8 → ack at cycle 10 with err = 1 and rdata = 0xDEADBEEF; FSM back in IDLE.
- reset_n pulsed low during WAIT → all outputs at reset values immediately; no ack for the aborted access; the next request issues normally.
- Buffer enabled: store 0xCAFEF00D to 0x40, then load 0x40 before the drain completes → store acked next cycle; load acked with 0xCAFEF00D and no extra mem_req.
- Buffer enabled: drain times out → wb_err = 1 and stays 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges the instruction-fetch and load/store ports onto a
// single external memory controller interface. Round-robin between I and D,
// one mem_req pulse per access, completion on mem_ready, timeout to an error
// response. Optional one-entry posted write buffer, compiled in by defining
// MEM_ARB_WRITE_BUFFER_EN.
module mem_port_arbiter #(
    parameter int          TIMEOUT_CYCLES = 2048,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_i_ack;
    logic             r_i_err;
    logic [31:0]      r_i_rdata;
    logic             r_d_ack;
    logic             r_d_err;
    logic [31:0]      r_d_rdata;
    logic [1:0]       r_grant;      // one-hot: bit0 = I, bit1 = D
    logic             r_last_d;     // 1 when D held the most recent grant
    logic [CNT_W-1:0] r_cnt;

    logic w_i_pend;
    logic w_d_pend;
    logic w_drain;
    logic w_pick_i;
    logic w_pick_d;
    logic w_timeout;
    logic w_done;

    // A request whose ack is visible this cycle is the old one, not a new one.
    assign w_i_pend = i_req & ~r_i_ack;

`ifdef MEM_ARB_WRITE_BUFFER_EN
    logic        r_wb_vld;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_drain;
    logic        r_wb_err;
    logic        w_st_accept;
    logic        w_fwd;

    assign w_st_accept = d_req & d_we & ~r_wb_vld & ~r_d_ack;
    assign w_fwd       = d_req & ~d_we & r_wb_vld & (d_addr == r_wb_addr) & ~r_d_ack;
    assign w_drain     = r_wb_vld;
    assign w_d_pend    = d_req & ~d_we & ~r_d_ack & ~w_fwd;
    assign wb_err      = r_wb_err;
`else
    assign w_drain     = 1'b0;
    assign w_d_pend    = d_req & ~r_d_ack;
    assign wb_err      = 1'b0;
`endif

    // Drain beats both ports; on an I/D tie the port not granted last wins.
    assign w_pick_i  = ~w_drain & w_i_pend & (~w_d_pend | r_last_d);
    assign w_pick_d  = ~w_drain & w_d_pend & ~w_pick_i;
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_done    = (r_state == S_WAIT) & (mem_ready | w_timeout);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ack     = r_i_ack;
    assign i_err     = r_i_err;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;

    // State register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: one issue cycle, one blind hold cycle, then wait for done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_drain | w_i_pend | w_d_pend) w_next = S_ISSUE;
            S_ISSUE: w_next = S_HOLD;
            S_HOLD:  w_next = S_WAIT;
            S_WAIT:  if (mem_ready | w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Grant latching, downstream drive, completion/timeout responses, buffer.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
            r_grant     <= 2'b00;
            r_last_d    <= 1'b1;
            r_cnt       <= '0;
`ifdef MEM_ARB_WRITE_BUFFER_EN
            r_wb_vld    <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_drain     <= 1'b0;
            r_wb_err    <= 1'b0;
`endif
        end else begin
            r_mem_req <= 1'b0;
            r_i_ack   <= 1'b0;
            r_i_err   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
`ifdef MEM_ARB_WRITE_BUFFER_EN
                    if (r_wb_vld) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wb_addr;
                        r_mem_wdata <= r_wb_data;
                        r_drain     <= 1'b1;
                    end else
`endif
                    if (w_pick_i) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_addr;
                        r_grant    <= 2'b01;
                        r_last_d   <= 1'b0;
                    end else if (w_pick_d) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_grant     <= 2'b10;
                        r_last_d    <= 1'b1;
                    end
                end
                S_HOLD: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_mem_we <= 1'b0;
                        r_grant  <= 2'b00;
                        if (r_grant[0]) begin
                            r_i_ack   <= 1'b1;
                            r_i_err   <= ~mem_ready;
                            r_i_rdata <= mem_ready ? mem_rdata : ERR_DATA;
                        end
                        if (r_grant[1]) begin
                            r_d_ack <= 1'b1;
                            r_d_err <= ~mem_ready;
                            if (!mem_ready)     r_d_rdata <= ERR_DATA;
                            else if (!r_mem_we) r_d_rdata <= mem_rdata;
                        end
`ifdef MEM_ARB_WRITE_BUFFER_EN
                        if (r_drain) begin
                            r_drain  <= 1'b0;
                            r_wb_vld <= 1'b0;
                            if (!mem_ready) r_wb_err <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
`ifdef MEM_ARB_WRITE_BUFFER_EN
            // Posted store and read-after-buffered-write forwarding, any state.
            if (w_st_accept) begin
                r_wb_vld  <= 1'b1;
                r_wb_addr <= d_addr;
                r_wb_data <= d_wdata;
                r_d_ack   <= 1'b1;
            end
            if (w_fwd) begin
                r_d_ack   <= 1'b1;
                r_d_rdata <= r_wb_data;
            end
`endif
        end
    end

endmodule
